program_memory: RTL and testbench



---
 rtl/program_memory.sv | 140 ++++++++++++++
 tb/tb_program_memory.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// program_memory
//
// Word-addressed instruction memory between the program loader and the core.
// A program image is streamed in over a valid/ready load port while the core
// is held in reset; once the image is complete the memory answers single-cycle
// fetch strobes with a registered instruction word one clock later.
//
// Optional feature macro: MEMORY_BOUNDS_CHECK_EN
//   defined   : fetch addresses with any bit set at or above ADDR_WIDTH return
//               NOP_WORD and set the sticky bounds_error flag.
//   undefined : fetch addresses wrap modulo DEPTH; bounds_error is tied to 0.
//
// Handshake: a load word transfers on a rising CLK edge where load_valid and
// load_ready are both 1. load_ready is decoded from the state register only,
// so it never depends combinationally on load_valid; load_valid may be
// dropped and raised freely and words are taken one per cycle.
//
// Ports:
//   CLK                 system clock, rising edge
//   reset               asynchronous, active-high
//   memory_address      word address from the core
//   memory_read_strobe  single-cycle fetch request
//   memory_read_data    registered instruction word (held between fetches)
//   load_valid          load word present
//   load_ready          load word may be accepted (EMPTY / LOADING)
//   load_data           program word
//   load_last           final word of the image
//   processor_reset     core reset, high until the image is complete
//   load_count          number of words loaded (ADDR_WIDTH+1 bits)
//   bounds_error        sticky out-of-range fetch flag
//   debug_state         current FSM state (EMPTY=0, LOADING=1, RUN=2)
module program_memory #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [31:0]           memory_address,
  input  logic                  memory_read_strobe,
  output logic [31:0]           memory_read_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  processor_reset,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  bounds_error,
  output logic [1:0]            debug_state
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]           mem [DEPTH];
  logic                  accept;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  count_full;
  logic                  fetch;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_hit;
  logic                  out_of_range;

  assign accept     = load_valid && load_ready;
  assign count_next = load_count + 1'b1;
  assign count_full = (count_next == DEPTH_CNT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    load_ready      = 1'b0;
    processor_reset = 1'b0;
    case (state_q)
      EMPTY, LOADING: begin
        load_ready      = 1'b1;
        processor_reset = 1'b1;
        // The final word may arrive straight from EMPTY (single-word image).
        if (accept) state_d = (load_last || count_full) ? RUN : LOADING;
      end
      RUN:     state_d = RUN;
      default: state_d = EMPTY;
    endcase
  end

  assign debug_state = state_q;

  // ---------------------------------------------------------------- load path
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)       load_count <= '0;
    else if (accept) load_count <= count_next;
  end

  // The array is deliberately not reset: load_count alone marks valid words.
  always_ff @(posedge CLK) begin
    if (accept) mem[load_count[ADDR_WIDTH-1:0]] <= load_data;
  end

  // ---------------------------------------------------------------- fetch path
  // Strobes before RUN are dropped, including one coinciding with the final
  // accept, so the core never sees a partially written array.
  assign fetch     = memory_read_strobe && (state_q == RUN);
  assign fetch_idx = memory_address[ADDR_WIDTH-1:0];
  assign fetch_hit = ({1'b0, fetch_idx} < load_count);

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign out_of_range = |memory_address[31:ADDR_WIDTH];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                      bounds_error <= 1'b0;
    else if (fetch && out_of_range) bounds_error <= 1'b1;
  end
`else
  // Upper address bits are ignored: fetches wrap modulo DEPTH.
  logic [31-ADDR_WIDTH:0] unused_addr_bits;
  assign unused_addr_bits = memory_address[31:ADDR_WIDTH];
  assign out_of_range     = 1'b0;
  assign bounds_error     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      memory_read_data <= '0;
    end else if (fetch) begin
      memory_read_data <= (fetch_hit && !out_of_range) ? mem[fetch_idx] : NOP_WORD;
    end
  end

endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef MEMORY_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic [31:0] memory_address = '0;
  logic        memory_read_strobe = 1'b0;
  logic [31:0] memory_read_data;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        processor_reset;
  logic [AW:0] load_count;
  logic        bounds_error;
  logic [1:0]  debug_state;

  program_memory #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .reset(reset),
    .memory_address(memory_address), .memory_read_strobe(memory_read_strobe),
    .memory_read_data(memory_read_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .processor_reset(processor_reset),
    .load_count(load_count), .bounds_error(bounds_error),
    .debug_state(debug_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];      // words the memory should hold, in load order
  bit          model_run;     // image complete
  logic [31:0] exp_data;
  logic        exp_bounds;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] addr);
    int idx;
    idx = int'(addr % DEPTH);
    if (BOUNDS && addr >= DEPTH) return NOP;
    if (idx < exp_q.size()) return exp_q[idx];
    return NOP;
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, ".count"},   32'(load_count),      32'(exp_q.size()));
    chk({tag, ".ready"},   32'(load_ready),      32'(!model_run));
    chk({tag, ".preset"},  32'(processor_reset), 32'(!model_run));
    chk({tag, ".rdata"},   memory_read_data,     exp_data);
    chk({tag, ".berr"},    32'(bounds_error),    32'(exp_bounds));
  endtask

  // ---------------------------------------------------------------- driver tasks
  // One clock cycle with the given inputs, then model update and checks.
  task automatic cycle(input string tag, input bit v, input logic [31:0] d, input bit last,
                       input bit strb, input logic [31:0] addr);
    bit run_pre;
    load_valid = v; load_data = d; load_last = last;
    memory_read_strobe = strb; memory_address = addr;
    run_pre = model_run;
    @(posedge CLK); #1;
    load_valid = 1'b0; load_last = 1'b0; memory_read_strobe = 1'b0;
    if (run_pre && strb) begin
      exp_data = model_fetch(addr);
      if (BOUNDS && addr >= DEPTH) exp_bounds = 1'b1;
    end
    if (!run_pre && v) begin
      exp_q.push_back(d);
      if (last || exp_q.size() == DEPTH) model_run = 1'b1;
    end
    chk_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fetch_and_hold(input string tag, input logic [31:0] addr);
    cycle(tag, 1'b0, 32'h0, 1'b0, 1'b1, addr);
    idle({tag, ".hold"});
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    exp_q.delete(); model_run = 1'b0; exp_data = '0; exp_bounds = 1'b0;
    chk_outputs(tag);
    @(posedge CLK); #3;
    reset = 1'b0;
    @(posedge CLK); #1;
    chk_outputs({tag, ".post"});
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'($urandom_range(0, 9));
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int guard;
    model_run = 1'b0; exp_data = '0; exp_bounds = 1'b0;
    #12;
    chk_outputs("reset");
    reset = 1'b0;
    @(posedge CLK); #1;

    // Three-word image; strobes before RUN are ignored.
    cycle("empty_strobe", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    cycle("ld0", 1'b1, 32'h00100093, 1'b0, 1'b0, 32'h0);
    cycle("loading_strobe", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    cycle("ld1", 1'b1, 32'h00108093, 1'b0, 1'b0, 32'h0);
    cycle("ld2_last_strobe", 1'b1, 32'h00108093, 1'b1, 1'b1, 32'h0);
    cycle("run_extra_load", 1'b1, 32'hdeadbeef, 1'b1, 1'b0, 32'h0);

    fetch_and_hold("f0", 32'd0);
    fetch_and_hold("f1", 32'd1);
    fetch_and_hold("f2", 32'd2);
    fetch_and_hold("f3", 32'd3);
    fetch_and_hold("f_oob", 32'h100);
    fetch_and_hold("f1_after_oob", 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle("rand_fetch_a", 1'b0, 32'h0, 1'b0, 1'b1, rand_addr());
      if ($urandom_range(0, 1) == 1) idle("rand_idle_a");
    end

    // Reset mid-load discards the partial image.
    do_reset("rst1");
    cycle("p_ld0", 1'b1, $urandom(), 1'b0, 1'b0, 32'h0);
    cycle("p_ld1", 1'b1, $urandom(), 1'b0, 1'b0, 32'h0);
    do_reset("rst_midload");
    cycle("one_word_last", 1'b1, 32'h00500113, 1'b1, 1'b0, 32'h0);
    fetch_and_hold("one_f1", 32'd1);
    fetch_and_hold("one_f0", 32'd0);

    // Fill the whole array without load_last, valid toggling randomly.
    do_reset("rst2");
    guard = 0;
    while (!model_run && guard < 3000) begin
      cycle("fill", 1'($urandom_range(0, 1)), $urandom(), 1'b0, 1'b0, 32'h0);
      guard++;
    end
    cycle("fill_extra", 1'b1, 32'hcafef00d, 1'b0, 1'b0, 32'h0);
    fetch_and_hold("fill_last", 32'(DEPTH - 1));
    for (int i = 0; i < 40; i++) begin
      cycle("rand_fetch_b", 1'b0, 32'h0, 1'b0, 1'b1,
            ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
